// File: rtl/tron_pkg.sv
// Shared types and helpers for the TRON direction controller.
package tron_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  localparam int MAX_PLAYERS = 4;

  // The bit-1 flip maps UP<->DOWN and RIGHT<->LEFT.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/tron_dir_fifo.sv
// Per-player pending-turn queue: head is entry 0, pops shift toward the head.
// With OVERWRITE set, a push into a full queue replaces the newest entry.
module tron_dir_fifo
  import tron_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  dir_t       din,
  output dir_t       head,
  output logic [2:0] count,
  output logic       full
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  dir_t       mem   [DEPTH];
  dir_t       mem_n [DEPTH];
  logic [2:0] count_n;

  // A pop is applied before the push so a full queue can accept a push on a pop cycle.
  always_comb begin
    mem_n   = mem;
    count_n = count;
    if (pop && (count != 3'd0)) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i + 1];
      count_n = count - 3'd1;
    end
    if (push) begin
      if (count_n != DEPTH_C) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (3'(i) == count_n) mem_n[i] = din;
        end
        count_n = count_n + 3'd1;
      end else if (OVERWRITE) begin
        mem_n[DEPTH - 1] = din;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    mem <= mem_n;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)      count <= 3'd0;
    else if (clear) count <= 3'd0;
    else            count <= count_n;
  end

  assign head = mem[0];
  assign full = (count == DEPTH_C);

endmodule

// File: rtl/tron_dir_ctrl.sv
// Multi-player TRON direction controller: filters turn requests and applies one per tick.
// Build option TRON_DIR_QUEUE_EN: per-player FIFO of QDEPTH entries; otherwise a single overwritable slot.
module tron_dir_ctrl
  import tron_pkg::*;
#(
  parameter int                         NUM_PLAYERS = 2,
  parameter int                         QDEPTH      = 2,
  parameter logic [2*NUM_PLAYERS-1:0]   INIT_DIRS   = 4'b1101
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       tick,
  input  logic [NUM_PLAYERS-1:0]     dir_valid,
  input  logic [2*NUM_PLAYERS-1:0]   dir_req,
  output logic [2*NUM_PLAYERS-1:0]   dir_out,
  output logic [NUM_PLAYERS-1:0]     turned,
  output logic [NUM_PLAYERS-1:0]     dropped,
  output logic [NUM_PLAYERS-1:0]     q_full
);

`ifdef TRON_DIR_QUEUE_EN
  localparam int FDEPTH    = QDEPTH;
  localparam bit OVERWRITE = 1'b0;
`else
  localparam int FDEPTH    = (QDEPTH > 1) ? 1 : QDEPTH;
  localparam bit OVERWRITE = 1'b1;
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    dir_t       req, head, cur_dir, chk_dir;
    logic [2:0] count;
    logic       full, pop, legal, push, drop, turned_r, dropped_r;

    assign req   = dir_t'(dir_req[2*p +: 2]);
    assign pop   = tick && (count != 3'd0);
    assign legal = dir_valid[p] && (req != chk_dir) && (req != opposite(chk_dir));

`ifdef TRON_DIR_QUEUE_EN
    dir_t ref_dir;

    assign chk_dir = ref_dir;
    assign push    = legal && (!full || pop);
    assign drop    = legal && full && !pop;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)      ref_dir <= dir_t'(INIT_DIRS[2*p +: 2]);
      else if (clear) ref_dir <= dir_t'(INIT_DIRS[2*p +: 2]);
      else if (push)  ref_dir <= req;
    end
`else
    // Check against the direction that will be in force after this cycle's pop.
    assign chk_dir = pop ? head : cur_dir;
    assign push    = legal;
    assign drop    = 1'b0;
`endif

    tron_dir_fifo #(
      .DEPTH     (FDEPTH),
      .OVERWRITE (OVERWRITE)
    ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clear    (clear),
      .push     (push),
      .pop      (pop),
      .din      (req),
      .head     (head),
      .count    (count),
      .full     (full)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        cur_dir   <= dir_t'(INIT_DIRS[2*p +: 2]);
        turned_r  <= 1'b0;
        dropped_r <= 1'b0;
      end else if (clear) begin
        cur_dir   <= dir_t'(INIT_DIRS[2*p +: 2]);
        turned_r  <= 1'b0;
        dropped_r <= 1'b0;
      end else begin
        if (pop) cur_dir <= head;
        turned_r  <= pop;
        dropped_r <= drop;
      end
    end

    assign dir_out[2*p +: 2] = cur_dir;
    assign turned[p]         = turned_r;
    assign dropped[p]        = dropped_r;
    assign q_full[p]         = full;
  end

endmodule

// File: tb/tb_tron_dir_ctrl.sv
// Bench for tron_dir_ctrl: vector table, corner sequences, then random traffic against a queue model.
module tb_tron_dir_ctrl;

  localparam int         NP   = 2;
  localparam int         QD   = 2;
  localparam logic [3:0] INIT = 4'b1101;
`ifdef TRON_DIR_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif
  localparam int         CAP = QMODE ? QD : 1;
  localparam logic [1:0] F0  = QMODE ? 2'b00 : 2'b01;
  localparam logic [1:0] F1  = QMODE ? 2'b00 : 2'b10;
  localparam logic [1:0] F3  = QMODE ? 2'b00 : 2'b11;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       clear    = 1'b0;
  logic       tick     = 1'b0;
  logic [1:0] dir_valid = 2'b00;
  logic [3:0] dir_req   = 4'b0000;
  logic [3:0] dir_out;
  logic [1:0] turned, dropped, q_full;

  int checks = 0;
  int errors = 0;

  tron_dir_ctrl #(
    .NUM_PLAYERS (NP),
    .QDEPTH      (QD),
    .INIT_DIRS   (INIT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .clear     (clear),
    .tick      (tick),
    .dir_valid (dir_valid),
    .dir_req   (dir_req),
    .dir_out   (dir_out),
    .turned    (turned),
    .dropped   (dropped),
    .q_full    (q_full)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       clr;
    logic       tk;
    logic [1:0] v;
    logic [3:0] rq;
    logic [3:0] e_dir;
    logic [1:0] e_turn;
    logic [1:0] e_drop;
    logic [1:0] e_full;
  } vec_t;

  vec_t tbl [11];

  // Reference model: each player is a list of pending directions plus the direction in force.
  logic [1:0] m_dout [NP];
  logic [1:0] m_ref  [NP];
  logic [1:0] mq     [NP][$];
  logic [1:0] m_turn, m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [3:0] iv;
    iv = INIT;
    for (int p = 0; p < NP; p++) begin
      m_dout[p] = iv[2*p +: 2];
      m_ref[p]  = iv[2*p +: 2];
      mq[p].delete();
    end
    m_turn = 2'b00;
    m_drop = 2'b00;
  endtask

  task automatic model_step(input logic clr, input logic tk, input logic [1:0] v, input logic [3:0] rq);
    logic [1:0] req, chk_d, head;
    bit popped, legal;
    if (clr) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      req    = rq[2*p +: 2];
      popped = tk && (mq[p].size() > 0);
      head   = 2'b00;
      if (popped) head = mq[p][0];
      if (QMODE)       chk_d = m_ref[p];
      else if (popped) chk_d = head;
      else             chk_d = m_dout[p];
      legal     = v[p] && (req != chk_d) && (req != (chk_d ^ 2'b10));
      m_turn[p] = popped;
      m_drop[p] = 1'b0;
      if (popped) begin
        m_dout[p] = head;
        void'(mq[p].pop_front());
      end
      if (legal) begin
        if (mq[p].size() < CAP) begin
          mq[p].push_back(req);
          m_ref[p] = req;
        end else if (QMODE) begin
          m_drop[p] = 1'b1;
        end else begin
          mq[p][CAP-1] = req;
        end
      end
    end
  endtask

  task automatic drive(input logic clr, input logic tk, input logic [1:0] v, input logic [3:0] rq);
    clear     = clr;
    tick      = tk;
    dir_valid = v;
    dir_req   = rq;
    model_step(clr, tk, v, rq);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    clear     = 1'b0;
    tick      = 1'b0;
    dir_valid = 2'b00;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic       rclr, rtk;
    logic [1:0] rv;
    logic [3:0] rrq;

    model_reset();
    //          clr   tk    v      rq       dir      turn   drop   full
    tbl[0]  = '{1'b0, 1'b0, 2'b01, 4'b0011, 4'b1101, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b1101, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 1'b0, 2'b01, 4'b0001, 4'b1101, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 2'b01, 4'b0010, 4'b1101, 2'b00, 2'b00, F0};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b1110, 2'b01, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 4'b0000, 4'b1110, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 2'b10, 4'b0000, 4'b1110, 2'b00, 2'b00, F1};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 4'b0011, 4'b0010, 2'b10, 2'b00, F0};
    tbl[8]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b0011, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 4'b0100, 4'b0011, 2'b00, 2'b00, F3};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'b11, 2'b00, 2'b00};

    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("reset_dir_out", 32'(dir_out), 32'(INIT));
    chk("reset_q_full",  32'(q_full),  32'd0);
    chk("reset_turned",  32'(turned),  32'd0);
    chk("reset_dropped", 32'(dropped), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].clr, tbl[i].tk, tbl[i].v, tbl[i].rq);
      chk($sformatf("tbl%0d_dir_out", i), 32'(dir_out), 32'(tbl[i].e_dir));
      chk($sformatf("tbl%0d_turned", i),  32'(turned),  32'(tbl[i].e_turn));
      chk($sformatf("tbl%0d_dropped", i), 32'(dropped), 32'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_q_full", i),  32'(q_full),  32'(tbl[i].e_full));
    end

    do_reset();
`ifdef TRON_DIR_QUEUE_EN
    drive(1'b0, 1'b0, 2'b01, 4'b0000);
    drive(1'b0, 1'b0, 2'b01, 4'b0011);
    chk("two_turns_full", 32'(q_full), 32'b01);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("two_turns_dir1", 32'(dir_out[1:0]), 32'b00);
    chk("two_turns_pulse1", 32'(turned), 32'b01);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("two_turns_dir2", 32'(dir_out[1:0]), 32'b11);
    chk("two_turns_pulse2", 32'(turned), 32'b01);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    chk("two_turns_idle", 32'(turned), 32'b00);

    drive(1'b0, 1'b0, 2'b10, 4'b0000);
    chk("p1_full_after1", 32'(q_full[1]), 32'd0);
    drive(1'b0, 1'b0, 2'b10, 4'b0100);
    chk("p1_full_after2", 32'(q_full[1]), 32'd1);
    drive(1'b0, 1'b0, 2'b10, 4'b1000);
    chk("p1_drop_pulse", 32'(dropped), 32'b10);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    chk("p1_drop_clears", 32'(dropped), 32'b00);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("p1_drain_dir", 32'(dir_out[3:2]), 32'b01);

    drive(1'b0, 1'b0, 2'b10, 4'b0000);
    drive(1'b0, 1'b0, 2'b10, 4'b1100);
    drive(1'b0, 1'b1, 2'b10, 4'b1000);
    chk("full_pop_push_nodrop", 32'(dropped), 32'b00);
    chk("full_pop_push_full",   32'(q_full[1]), 32'd1);
    chk("full_pop_push_dir",    32'(dir_out[3:2]), 32'b00);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("full_pop_push_next1", 32'(dir_out[3:2]), 32'b11);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("full_pop_push_next2", 32'(dir_out[3:2]), 32'b10);

    drive(1'b0, 1'b0, 2'b01, 4'b0000);
    drive(1'b0, 1'b0, 2'b01, 4'b0001);
    chk("pre_clear_full", 32'(q_full), 32'b01);
`else
    drive(1'b0, 1'b0, 2'b01, 4'b0000);
    chk("slot_hold_full", 32'(q_full), 32'b01);
    drive(1'b0, 1'b0, 2'b01, 4'b0010);
    chk("slot_overwrite_full", 32'(q_full), 32'b01);
    chk("slot_no_drop", 32'(dropped), 32'b00);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("slot_apply_dir", 32'(dir_out[1:0]), 32'b10);
    chk("slot_apply_pulse", 32'(turned), 32'b01);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("slot_empty_dir", 32'(dir_out[1:0]), 32'b10);
    chk("slot_empty_pulse", 32'(turned), 32'b00);

    drive(1'b0, 1'b0, 2'b01, 4'b0000);
    chk("slot_reverse_ignored", 32'(q_full), 32'b00);

    drive(1'b0, 1'b0, 2'b10, 4'b0000);
    drive(1'b0, 1'b0, 2'b10, 4'b1000);
    chk("slot_p1_full", 32'(q_full), 32'b10);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("slot_p1_dir", 32'(dir_out[3:2]), 32'b10);
    chk("slot_p1_pulse", 32'(turned), 32'b10);

    drive(1'b0, 1'b0, 2'b01, 4'b0011);
    drive(1'b0, 1'b0, 2'b01, 4'b0001);
    chk("pre_clear_full", 32'(q_full), 32'b01);
`endif
    drive(1'b1, 1'b1, 2'b00, 4'b0000);
    chk("clear_dir_out", 32'(dir_out), 32'(INIT));
    chk("clear_q_full",  32'(q_full),  32'd0);
    chk("clear_turned",  32'(turned),  32'd0);
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    chk("after_clear_dir", 32'(dir_out), 32'(INIT));
    chk("after_clear_turned", 32'(turned), 32'd0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_dir", 32'(dir_out), 32'(INIT));
        chk("async_reset_full", 32'(q_full), 32'd0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        model_reset();
      end
      rclr = ($urandom_range(0, 63) == 0);
      rtk  = ($urandom_range(0, 2) == 0);
      rv   = 2'($urandom);
      rrq  = 4'($urandom);
      drive(rclr, rtk, rv, rrq);
      chk("rand_dir_out", 32'(dir_out), 32'({m_dout[1], m_dout[0]}));
      chk("rand_turned",  32'(turned),  32'(m_turn));
      chk("rand_dropped", 32'(dropped), 32'(m_drop));
      chk("rand_q_full",  32'(q_full),
          32'({(mq[1].size() == CAP), (mq[0].size() == CAP)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
